// File: rtl/wb_stage.sv
// RV32I write-back stage: one-entry WB register fed from MEM with load alignment, fault detection and retire counting.
// MEM->WB latency 1 cycle; hold freezes the entry and suppresses its register-file write until released.
module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [1:0]  mem_wb_sel,
    input  logic [2:0]  mem_funct3,
    input  logic [1:0]  mem_addr_lo,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_load_data,
    input  logic [31:0] mem_pc_plus4,
    input  logic [31:0] mem_imm,
    input  logic        hold,
    output logic        wb_valid,
    output logic        reg_write,
    output logic [4:0]  rd,
    output logic [31:0] wb_data,
    output logic        load_fault,
    output logic [63:0] retire_count
);

    logic        valid_q, valid_d;
    logic        regw_q, regw_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic        fault_q, fault_d;
    logic [63:0] retire_q, retire_d;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_res;
    logic        load_bad;

    assign ld_byte = mem_load_data[{mem_addr_lo, 3'b000} +: 8];
    assign ld_half = mem_load_data[{mem_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        load_res = 32'd0;
        load_bad = 1'b0;
        unique case (mem_funct3)
            3'b000:  load_res = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_res = {24'd0, ld_byte};
            3'b001: begin
                load_res = {{16{ld_half[15]}}, ld_half};
                load_bad = mem_addr_lo[0];
            end
            3'b101: begin
                load_res = {16'd0, ld_half};
                load_bad = mem_addr_lo[0];
            end
            3'b010: begin
                load_res = mem_load_data;
                load_bad = (mem_addr_lo != 2'b00);
            end
            default: load_bad = 1'b1;
        endcase
    end

    always_comb begin
        valid_d  = valid_q;
        regw_d   = regw_q;
        rd_d     = rd_q;
        data_d   = data_q;
        fault_d  = fault_q;
        retire_d = retire_q;
        if (!hold) begin
            // The outgoing entry retires on the same edge that replaces it.
            if (valid_q && !fault_q) begin
                retire_d = retire_q + 64'd1;
            end
            valid_d = mem_valid;
            regw_d  = mem_reg_write;
            rd_d    = mem_rd;
            fault_d = mem_valid && (mem_wb_sel == 2'b01) && load_bad;
            unique case (mem_wb_sel)
                2'b00:   data_d = mem_alu_result;
                2'b01:   data_d = load_bad ? 32'd0 : load_res;
                2'b10:   data_d = mem_pc_plus4;
                default: data_d = mem_imm;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            regw_q   <= 1'b0;
            rd_q     <= 5'd0;
            data_q   <= 32'd0;
            fault_q  <= 1'b0;
            retire_q <= 64'd0;
        end else begin
            valid_q  <= valid_d;
            regw_q   <= regw_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            fault_q  <= fault_d;
            retire_q <= retire_d;
        end
    end

    assign wb_valid     = valid_q;
    assign rd           = rd_q;
    assign wb_data      = data_q;
    assign load_fault   = fault_q;
    assign retire_count = retire_q;
    assign reg_write    = valid_q && regw_q && (rd_q != 5'd0) && !fault_q && !hold && !reset;

endmodule
